// File: rtl/sequenza_partita.sv
// Match sequencer for the rock-paper-scissors core: drives set-up, collects one
// move per player over valid/ready, presents the pair, and tracks results/timeout.
module sequenza_partita #(
  parameter int SETUP_CICLI = 2,
  parameter int TIMEOUT     = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       AVVIA,
  input  logic [3:0] CONFIG,
  input  logic [1:0] MOSSA1,
  input  logic [1:0] MOSSA2,
  input  logic       VALIDO1,
  input  logic       VALIDO2,
  output logic       PRONTO1,
  output logic       PRONTO2,
  output logic       INIZIA,
  output logic [1:0] PRIMO,
  output logic [1:0] SECONDO,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  output logic [1:0] RISULTATO,
  output logic       MANCHE_VALIDA,
  output logic       RIFIUTATA,
  output logic [1:0] VINCITORE,
  output logic       FINITA,
  output logic       SCADUTO
);

  localparam int SW = (SETUP_CICLI > 1) ? $clog2(SETUP_CICLI) : 1;
  localparam logic [SW-1:0] SCNT_LAST = SW'(SETUP_CICLI - 1);
  localparam logic [7:0]    CNT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, RACCOLTA, GIOCA, ATTESA, FINE} stato_t;

  stato_t        r_state;
  logic [SW-1:0] r_scnt;
  logic [7:0]    r_cnt;
  logic [1:0]    r_slot1, r_slot2;
  logic          r_iniz, r_mv, r_rif, r_fin, r_scad;
  logic [1:0]    r_primo, r_sec, r_ris, r_vinc;

  logic       w_cap1, w_cap2, w_full1, w_full2;
  logic [1:0] w_s1, w_s2;

  // A slot holding 00 is empty: 00 is never a legal move, so it doubles as the flag.
  assign PRONTO1 = (r_state == RACCOLTA) && (r_slot1 == 2'b00);
  assign PRONTO2 = (r_state == RACCOLTA) && (r_slot2 == 2'b00);
  assign w_cap1  = VALIDO1 && PRONTO1 && (MOSSA1 != 2'b00);
  assign w_cap2  = VALIDO2 && PRONTO2 && (MOSSA2 != 2'b00);
  assign w_s1    = w_cap1 ? MOSSA1 : r_slot1;
  assign w_s2    = w_cap2 ? MOSSA2 : r_slot2;
  assign w_full1 = (w_s1 != 2'b00);
  assign w_full2 = (w_s2 != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_scnt  <= '0;
      r_cnt   <= '0;
      r_slot1 <= '0;
      r_slot2 <= '0;
      r_iniz  <= 1'b0;
      r_primo <= '0;
      r_sec   <= '0;
      r_ris   <= '0;
      r_mv    <= 1'b0;
      r_rif   <= 1'b0;
      r_vinc  <= '0;
      r_fin   <= 1'b0;
      r_scad  <= 1'b0;
    end else begin
      r_mv  <= 1'b0;
      r_rif <= 1'b0;
      if (AVVIA) begin
        // Restart from any state: abort the match and relatch the turn code.
        r_state <= SETUP;
        r_scnt  <= '0;
        r_cnt   <= '0;
        r_slot1 <= '0;
        r_slot2 <= '0;
        r_iniz  <= 1'b1;
        r_primo <= CONFIG[3:2];
        r_sec   <= CONFIG[1:0];
        r_ris   <= '0;
        r_vinc  <= '0;
        r_fin   <= 1'b0;
        r_scad  <= 1'b0;
      end else begin
        case (r_state)
          SETUP: begin
            if (r_scnt == SCNT_LAST) begin
              r_state <= RACCOLTA;
              r_iniz  <= 1'b0;
              r_primo <= '0;
              r_sec   <= '0;
            end else begin
              r_scnt <= r_scnt + SW'(1);
            end
          end
          RACCOLTA: begin
            r_slot1 <= w_s1;
            r_slot2 <= w_s2;
            r_cnt   <= r_cnt + 8'd1;
            if (w_full1 && w_full2) begin
              r_state <= GIOCA;
              r_primo <= w_s1;
              r_sec   <= w_s2;
            end else if (r_cnt == CNT_LAST) begin
              // Same-edge captures are already folded into w_full*, so they beat the timeout.
              r_state <= FINE;
              r_scad  <= 1'b1;
              r_fin   <= 1'b1;
              r_vinc  <= (!w_full1 && !w_full2) ? 2'b11 : {w_full2, w_full1};
              r_slot1 <= '0;
              r_slot2 <= '0;
            end
          end
          GIOCA: begin
            r_state <= ATTESA;
            r_primo <= '0;
            r_sec   <= '0;
          end
          ATTESA: begin
            r_slot1 <= '0;
            r_slot2 <= '0;
            r_cnt   <= '0;
            if (MANCHE == 2'b00) begin
              r_rif   <= 1'b1;
              r_state <= RACCOLTA;
            end else begin
              r_ris <= MANCHE;
              r_mv  <= 1'b1;
              if (PARTITA != 2'b00) begin
                r_vinc  <= PARTITA;
                r_fin   <= 1'b1;
                r_state <= FINE;
              end else begin
                r_state <= RACCOLTA;
              end
            end
          end
          IDLE, FINE: ;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign INIZIA        = r_iniz;
  assign PRIMO         = r_primo;
  assign SECONDO       = r_sec;
  assign RISULTATO     = r_ris;
  assign MANCHE_VALIDA = r_mv;
  assign RIFIUTATA     = r_rif;
  assign VINCITORE     = r_vinc;
  assign FINITA        = r_fin;
  assign SCADUTO       = r_scad;

endmodule

// File: tb/tb_sequenza_partita.sv
// Directed bench for sequenza_partita: set-up, rounds, reject, timeout and restart/reset.
module tb_sequenza_partita;

  logic       clk, reset, AVVIA, VALIDO1, VALIDO2;
  logic [3:0] CONFIG;
  logic [1:0] MOSSA1, MOSSA2, MANCHE, PARTITA;
  logic       PRONTO1, PRONTO2, INIZIA, MANCHE_VALIDA, RIFIUTATA, FINITA, SCADUTO;
  logic [1:0] PRIMO, SECONDO, RISULTATO, VINCITORE;

  int n_chk = 0;
  int n_err = 0;

  sequenza_partita #(.SETUP_CICLI(2), .TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .AVVIA(AVVIA), .CONFIG(CONFIG),
    .MOSSA1(MOSSA1), .MOSSA2(MOSSA2), .VALIDO1(VALIDO1), .VALIDO2(VALIDO2),
    .PRONTO1(PRONTO1), .PRONTO2(PRONTO2), .INIZIA(INIZIA),
    .PRIMO(PRIMO), .SECONDO(SECONDO), .MANCHE(MANCHE), .PARTITA(PARTITA),
    .RISULTATO(RISULTATO), .MANCHE_VALIDA(MANCHE_VALIDA), .RIFIUTATA(RIFIUTATA),
    .VINCITORE(VINCITORE), .FINITA(FINITA), .SCADUTO(SCADUTO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic avvia(input logic [3:0] cfg);
    CONFIG = cfg;
    AVVIA  = 1'b1;
    step();
    AVVIA  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; AVVIA = 1'b0; CONFIG = '0;
    MOSSA1 = '0; MOSSA2 = '0; VALIDO1 = 1'b0; VALIDO2 = 1'b0;
    MANCHE = '0; PARTITA = '0;
    steps(2);
    chk("rst_outs", {INIZIA, PRIMO, SECONDO, MANCHE_VALIDA, RIFIUTATA, FINITA}, 8'h00);
    chk("rst_res", {RISULTATO, VINCITORE, SCADUTO, PRONTO1, PRONTO2}, 8'h00);
    reset = 1'b0;
    step();
    chk("idle_inizia", INIZIA, 0);

    // Set-up: INIZIA high for two cycles carrying CONFIG
    avvia(4'b0001);
    chk("setup1_inizia", INIZIA, 1);
    chk("setup1_pair", {PRIMO, SECONDO}, 8'b0001);
    chk("setup1_pronto", {PRONTO1, PRONTO2}, 0);
    step();
    chk("setup2_inizia", INIZIA, 1);
    step();
    chk("racc_inizia", INIZIA, 0);
    chk("racc_pair", {PRIMO, SECONDO}, 0);
    chk("racc_pronto", {PRONTO1, PRONTO2}, 2'b11);

    // Round 1: P1 first, P2 a few cycles later, core reports P1 wins the round
    MANCHE = 2'b01; PARTITA = 2'b00;
    MOSSA1 = 2'b01; VALIDO1 = 1'b1;
    step();
    VALIDO1 = 1'b0;
    chk("p1_cap_pronto", {PRONTO1, PRONTO2}, 2'b01);
    steps(3);
    MOSSA2 = 2'b11; VALIDO2 = 1'b1;
    step();
    VALIDO2 = 1'b0;
    chk("gioca_pair", {PRIMO, SECONDO}, 8'b0111);
    chk("gioca_pronto", {PRONTO1, PRONTO2}, 0);
    step();
    chk("attesa_pair", {PRIMO, SECONDO}, 0);
    chk("attesa_mv", MANCHE_VALIDA, 0);
    step();
    chk("r1_mv", MANCHE_VALIDA, 1);
    chk("r1_ris", RISULTATO, 2'b01);
    chk("r1_pronto", {PRONTO1, PRONTO2}, 2'b11);
    step();
    chk("r1_mv_pulse", MANCHE_VALIDA, 0);

    // Round 2: simultaneous moves, core rejects the pair
    MANCHE = 2'b00;
    MOSSA1 = 2'b01; MOSSA2 = 2'b10; VALIDO1 = 1'b1; VALIDO2 = 1'b1;
    step();
    VALIDO1 = 1'b0; VALIDO2 = 1'b0;
    chk("r2_gioca_pair", {PRIMO, SECONDO}, 8'b0110);
    step();
    chk("r2_single_gioca", {PRIMO, SECONDO}, 0);
    step();
    chk("r2_rif", {RIFIUTATA, MANCHE_VALIDA}, 2'b10);
    chk("r2_ris_kept", RISULTATO, 2'b01);
    chk("r2_pronto", {PRONTO1, PRONTO2}, 2'b11);
    step();
    chk("r2_rif_pulse", RIFIUTATA, 0);

    // A 00 move is never captured
    MOSSA1 = 2'b00; VALIDO1 = 1'b1;
    step();
    VALIDO1 = 1'b0;
    chk("null_move_pronto", PRONTO1, 1);

    // Timeout: P1 moves on the first RACCOLTA edge, P2 stays silent
    avvia(4'b0000);
    chk("restart_ris_clr", RISULTATO, 0);
    steps(2);
    MOSSA1 = 2'b10; VALIDO1 = 1'b1;
    step();
    VALIDO1 = 1'b0;
    steps(8);
    chk("tmo_before", {FINITA, SCADUTO}, 0);
    step();
    chk("tmo_fin_scad", {FINITA, SCADUTO}, 2'b11);
    chk("tmo_vinc", VINCITORE, 2'b01);
    chk("tmo_pronto", {PRONTO1, PRONTO2}, 0);
    step();
    chk("tmo_held", {FINITA, SCADUTO, VINCITORE}, 4'b1101);

    // P2 capture on the tenth edge beats the timeout; core ends the match
    avvia(4'b0000);
    chk("restart_clr", {FINITA, SCADUTO, VINCITORE}, 0);
    steps(2);
    MOSSA1 = 2'b10; VALIDO1 = 1'b1;
    step();
    VALIDO1 = 1'b0;
    steps(8);
    MANCHE = 2'b10; PARTITA = 2'b10;
    MOSSA2 = 2'b11; VALIDO2 = 1'b1;
    step();
    VALIDO2 = 1'b0;
    chk("late_no_tmo", {FINITA, SCADUTO}, 0);
    chk("late_pair", {PRIMO, SECONDO}, 8'b1011);
    steps(2);
    chk("late_mv_ris", {MANCHE_VALIDA, RISULTATO}, 3'b110);
    chk("late_match", {FINITA, SCADUTO, VINCITORE}, 4'b1010);

    // Restart from FINE, then AVVIA mid-RACCOLTA with slot1 full
    avvia(4'b1010);
    chk("fine_restart_pair", {INIZIA, PRIMO, SECONDO}, 5'b11010);
    chk("fine_restart_clr", {FINITA, VINCITORE, RISULTATO}, 0);
    steps(2);
    MOSSA1 = 2'b01; VALIDO1 = 1'b1;
    step();
    VALIDO1 = 1'b0;
    chk("mid_slot1_full", PRONTO1, 0);
    avvia(4'b0011);
    chk("mid_restart_pair", {INIZIA, PRIMO, SECONDO}, 5'b10011);
    steps(2);
    chk("mid_slots_clr", {PRONTO1, PRONTO2}, 2'b11);

    // Asynchronous reset while the pair is on the bus
    MOSSA1 = 2'b11; MOSSA2 = 2'b01; VALIDO1 = 1'b1; VALIDO2 = 1'b1;
    step();
    VALIDO1 = 1'b0; VALIDO2 = 1'b0;
    chk("pre_rst_pair", {PRIMO, SECONDO}, 8'b1101);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pair", {INIZIA, PRIMO, SECONDO}, 0);
    chk("async_rst_flags", {MANCHE_VALIDA, RIFIUTATA, FINITA, SCADUTO, VINCITORE, RISULTATO}, 0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_idle", {PRONTO1, PRONTO2, INIZIA}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sequenza_partita.md
# sequenza_partita

Match sequencer for the rock-paper-scissors game core. It runs the core's start/set-up protocol, collects one move from each player through independent valid/ready channels, and presents both moves to the core as a single-cycle pair. It reads back the round and match results, enforces a per-round move timeout, and reports round outcomes and the match winner to the top level. The block sits between the player input logic and the game core; it is the only driver of the core's INIZIA, PRIMO and SECONDO.

## Interface
- SETUP_CICLI, 2: cycles INIZIA is held high during set-up (≥1).
- TIMEOUT, 200: cycles allowed per round for both moves to arrive (≥2, fits 8 bits).
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- AVVIA  in  1  start/restart request (level, sampled each edge).
- CONFIG  in  4  turn-count code sent to core during set-up; the core plays CONFIG+4 turns.
- MOSSA1, MOSSA2  in  2  player move (01/10/11; 00 = none).
- VALIDO1, VALIDO2  in  1  move valid.
- PRONTO1, PRONTO2  out  1  slot ready to accept a move.
- INIZIA  out  1  to core.
- PRIMO, SECONDO  out  2  to core.
- MANCHE, PARTITA  in  2  from core.
- RISULTATO  out  2  last round result (01 P1, 10 P2, 11 draw).
- MANCHE_VALIDA  out  1  one-cycle pulse when RISULTATO updates.
- RIFIUTATA  out  1  one-cycle pulse when the core rejects a pair.
- VINCITORE  out  2  match winner (01, 10, 11 draw), held.
- FINITA  out  1  match over, held until the next start.
- SCADUTO  out  1  held high if the match ended by timeout.

## Operation
- States: IDLE, SETUP, RACCOLTA, GIOCA, ATTESA, FINE.
- Reset: IDLE; all outputs 0; slots empty; counters 0.
- IDLE: INIZIA=0, PRIMO=SECONDO=00. AVVIA → SETUP. CONFIG is latched on the same edge.
- SETUP: INIZIA=1, {PRIMO,SECONDO}=latched CONFIG for exactly SETUP_CICLI cycles, then RACCOLTA. Entering SETUP clears RISULTATO, VINCITORE, FINITA and SCADUTO.
- RACCOLTA: INIZIA=0, PRIMO=SECONDO=00 (the core treats 00 as an invalid move and ignores it).
  - PRONTOn = (state==RACCOLTA) & slot n empty. This is decoded combinationally from registers.
  - Move n is captured when VALIDOn & PRONTOn & MOSSAn≠00. A 00 move is never captured.
  - The two channels are independent; captures may arrive in any order or together.
  - Both slots full after an edge → GIOCA.
- GIOCA (1 cycle): PRIMO=slot1, SECONDO=slot2 → ATTESA.
- ATTESA (1 cycle): PRIMO=SECONDO=00. MANCHE and PARTITA are sampled at the end of this cycle.
  - MANCHE=00: pulse RIFIUTATA, clear both slots, return to RACCOLTA.
  - MANCHE≠00: RISULTATO=MANCHE, pulse MANCHE_VALIDA, clear slots.
    - PARTITA≠00: VINCITORE=PARTITA, FINITA=1, go to FINE.
    - PARTITA=00: return to RACCOLTA.
- Timeout:
  - The 8-bit round counter clears on every entry to RACCOLTA and increments each RACCOLTA cycle.
  - It fires when the counter reaches TIMEOUT−1 and a slot is still empty after that edge's captures. A capture on the same edge therefore beats the timeout.
  - On timeout: SCADUTO=1, FINITA=1, VINCITORE=01 if only slot1 is full, 10 if only slot2 is full, 11 if both are empty. Then go to FINE.
- FINE: core drive as in IDLE; outputs held. AVVIA → SETUP.
- Priority: reset > AVVIA (from any state, aborts the match, relatches CONFIG) > timeout > normal flow.

## Timing
- AVVIA seen at edge k → INIZIA=1 during cycles k+1 … k+SETUP_CICLI. RACCOLTA starts at k+SETUP_CICLI+1.
- Second move captured at edge t → GIOCA in cycle t+1, ATTESA in cycle t+2. MANCHE_VALIDA or RIFIUTATA is high in cycle t+3.
- The pair is on PRIMO/SECONDO for exactly one cycle; every other non-SETUP cycle drives 00.
- All outputs except PRONTOn are registered. Pulses last exactly one cycle.
- reset asserted mid-round: immediate return to IDLE, INIZIA=0, pending moves discarded.

## Test plan
- SETUP_CICLI=2, CONFIG=0001, pulse AVVIA → INIZIA high exactly 2 cycles with PRIMO=00, SECONDO=01; then PRONTO1=PRONTO2=1.
- P1 sends 01 at cycle 3, P2 sends 11 at cycle 7 → PRIMO/SECONDO=01/11 for one cycle; MANCHE_VALIDA with RISULTATO=01 three cycles after the P2 capture.
- P1 repeats its winning move 01 in the next round → core returns MANCHE=00 → RIFIUTATA pulse, both PRONTO re-assert, RISULTATO unchanged.
- MOSSA1=00 with VALIDO1=1 → no capture, PRONTO1 stays 1. Both players send simultaneously → a single GIOCA cycle.
- P2 silent for TIMEOUT=10 cycles after P1 sends 10 → SCADUTO=1, FINITA=1, VINCITORE=01. P2 capturing on the 10th edge → no timeout.
- AVVIA mid-RACCOLTA with slot1 full → slots cleared, SETUP restarts, VINCITORE and FINITA cleared. reset pulse mid-GIOCA → all outputs 0 asynchronously.
